// File: rtl/ram_slot_allocator_if.sv
// Handshake bundle between the slot allocator, its requesters and the external FirstZero finder.
// The slave side is the allocator; the master side drives requests and the finder result.
interface ram_slot_allocator_if #(
    parameter int SIZE_RAM     = 32,
    parameter int SIZE_RAM_LOG = 5
);
    logic                    flush;
    logic                    alloc_req;
    logic                    free_en;
    logic [SIZE_RAM_LOG-1:0] free_idx;
    logic [SIZE_RAM_LOG-1:0] first_zero;
    logic [SIZE_RAM-1:0]     ram_valid;
    logic                    alloc_gnt;
    logic                    alloc_fail;
    logic [SIZE_RAM_LOG-1:0] alloc_idx;
    logic [SIZE_RAM_LOG:0]   used_cnt;
    logic                    full;
    logic                    empty;
    logic                    err_free;

    modport slave (
        input  flush, alloc_req, free_en, free_idx, first_zero,
        output ram_valid, alloc_gnt, alloc_fail, alloc_idx, used_cnt, full, empty, err_free
    );

    modport master (
        output flush, alloc_req, free_en, free_idx, first_zero,
        input  ram_valid, alloc_gnt, alloc_fail, alloc_idx, used_cnt, full, empty, err_free
    );
endinterface

// File: rtl/ram_slot_allocator.sv
// Owns the RAM slot occupancy bitmap: grants the finder's lowest free slot, retires freed
// slots, tracks occupancy and flags frees of unallocated slots. Every output is registered.
module ram_slot_allocator #(
    parameter int SIZE_RAM     = 32,
    parameter int SIZE_RAM_LOG = 5
) (
    input logic                  i_clk,
    input logic                  i_rst,
    ram_slot_allocator_if.slave  io_bus
);
    localparam int CNT_W = SIZE_RAM_LOG + 1;

    logic [SIZE_RAM-1:0]     r_valid;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_full;
    logic                    r_empty;
    logic                    r_gnt;
    logic                    r_fail;
    logic [SIZE_RAM_LOG-1:0] r_idx;
    logic                    r_err;

    logic                    w_grant;
    logic                    w_fail;
    logic                    w_free_ok;
    logic                    w_free_bad;
    logic [SIZE_RAM-1:0]     w_set_mask;
    logic [SIZE_RAM-1:0]     w_clr_mask;
    logic [SIZE_RAM-1:0]     w_valid_next;
    logic [CNT_W-1:0]        w_cnt_next;

    // Fullness comes from the registered flag only; the finder wraps to 0 when every bit is set.
    // Alloc and free both look at the pre-update bitmap, so a free never rescues a full alloc.
    always_comb begin
        w_grant    = io_bus.alloc_req && !r_full;
        w_fail     = io_bus.alloc_req && r_full;
        w_free_ok  = io_bus.free_en && r_valid[io_bus.free_idx];
        w_free_bad = io_bus.free_en && !r_valid[io_bus.free_idx];
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_grant) begin
            w_set_mask[io_bus.first_zero] = 1'b1;
        end
        if (w_free_ok) begin
            w_clr_mask[io_bus.free_idx] = 1'b1;
        end
        w_valid_next = (r_valid | w_set_mask) & ~w_clr_mask;
        w_cnt_next   = r_cnt + CNT_W'(w_grant) - CNT_W'(w_free_ok);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_gnt   <= 1'b0;
            r_fail  <= 1'b0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else if (io_bus.flush) begin
            r_valid <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_gnt   <= 1'b0;
            r_fail  <= 1'b0;
            r_idx   <= '0;
        end else begin
            r_valid <= w_valid_next;
            r_cnt   <= w_cnt_next;
            r_full  <= &w_valid_next;
            r_empty <= (w_cnt_next == '0);
            r_gnt   <= w_grant;
            r_fail  <= w_fail;
            if (w_grant) begin
                r_idx <= io_bus.first_zero;
            end
            if (w_free_bad) begin
                r_err <= 1'b1;
            end
        end
    end

    assign io_bus.ram_valid  = r_valid;
    assign io_bus.used_cnt   = r_cnt;
    assign io_bus.full       = r_full;
    assign io_bus.empty      = r_empty;
    assign io_bus.alloc_gnt  = r_gnt;
    assign io_bus.alloc_fail = r_fail;
    assign io_bus.alloc_idx  = r_idx;
    assign io_bus.err_free   = r_err;
endmodule

// File: tb/tb_ram_slot_allocator.sv
// Bench for ram_slot_allocator: behavioural bitmap model feeding a scoreboard queue, a vector
// table for the full-bitmap corner cases, and hand sequences for reset/flush/illegal frees.
module tb_ram_slot_allocator;
    logic clk;
    logic rst;

    ram_slot_allocator_if #(.SIZE_RAM(32), .SIZE_RAM_LOG(5)) bus ();

    ram_slot_allocator #(.SIZE_RAM(32), .SIZE_RAM_LOG(5)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External FirstZero finder: lowest clear bit, 0 when the bitmap is full.
    always_comb begin
        bus.first_zero = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (!bus.ram_valid[i]) bus.first_zero = 5'(i);
        end
    end

    typedef struct {
        logic        gnt;
        logic        fail;
        logic [4:0]  idx;
        logic [31:0] valid;
        logic [5:0]  cnt;
        logic        full;
        logic        empty;
        logic        err;
    } exp_t;

    typedef struct {
        logic       fl;
        logic       al;
        logic       fe;
        logic [4:0] fi;
        logic       e_gnt;
        logic       e_fail;
        logic [4:0] e_idx;
        logic [5:0] e_cnt;
    } vec_t;

    exp_t sbq[$];
    vec_t vec[6];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_valid;
    logic [4:0]  m_idx;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.flush = 1'b0; bus.alloc_req = 1'b0; bus.free_en = 1'b0; bus.free_idx = 5'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_valid = '0; m_idx = '0; m_err = 1'b0;
        sbq.delete();
        chk("rst_valid", bus.ram_valid, 32'h0);
        chk("rst_cnt", 32'(bus.used_cnt), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_gnt", 32'(bus.alloc_gnt), 32'd0);
        chk("rst_fail", 32'(bus.alloc_fail), 32'd0);
        chk("rst_idx", 32'(bus.alloc_idx), 32'd0);
        chk("rst_err", 32'(bus.err_free), 32'd0);
    endtask

    // One cycle of stimulus: model predicts, scoreboard holds the prediction until the DUT answers.
    task automatic step(input logic fl, input logic al, input logic fe, input logic [4:0] fi);
        exp_t        e;
        exp_t        got;
        int          lo;
        logic        g;
        logic        f;
        logic [31:0] nv;
        bus.flush = fl; bus.alloc_req = al; bus.free_en = fe; bus.free_idx = fi;
        lo = -1;
        for (int i = 0; i < 32; i++) if (!m_valid[i] && lo < 0) lo = i;
        g = 1'b0; f = 1'b0;
        if (fl) begin
            m_valid = '0; m_idx = '0;
        end else begin
            g = al && (lo >= 0);
            f = al && (lo < 0);
            nv = m_valid;
            if (fe) begin
                if (m_valid[fi]) nv[fi] = 1'b0;
                else m_err = 1'b1;
            end
            if (g) begin
                nv[lo] = 1'b1;
                m_idx = 5'(lo);
            end
            m_valid = nv;
        end
        e.gnt = g; e.fail = f; e.idx = m_idx; e.valid = m_valid;
        e.cnt = 6'($countones(m_valid));
        e.full = (m_valid == 32'hFFFF_FFFF); e.empty = (m_valid == 32'h0); e.err = m_err;
        sbq.push_back(e);
        @(posedge clk); #1;
        bus.flush = 1'b0; bus.alloc_req = 1'b0; bus.free_en = 1'b0;
        got.gnt = bus.alloc_gnt; got.fail = bus.alloc_fail; got.idx = bus.alloc_idx;
        got.valid = bus.ram_valid; got.cnt = bus.used_cnt; got.full = bus.full;
        got.empty = bus.empty; got.err = bus.err_free;
        e = sbq.pop_front();
        chk("sb_gnt", 32'(got.gnt), 32'(e.gnt));
        chk("sb_fail", 32'(got.fail), 32'(e.fail));
        chk("sb_idx", 32'(got.idx), 32'(e.idx));
        chk("sb_valid", got.valid, e.valid);
        chk("sb_cnt", 32'(got.cnt), 32'(e.cnt));
        chk("sb_full", 32'(got.full), 32'(e.full));
        chk("sb_empty", 32'(got.empty), 32'(e.empty));
        chk("sb_err", 32'(got.err), 32'(e.err));
    endtask

    initial begin
        // From full (last grant 31): free 7, free 3, two allocs, alloc+free 5 while full, alloc.
        vec[0] = '{1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 5'd31, 6'd31};
        vec[1] = '{1'b0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 5'd31, 6'd30};
        vec[2] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd3,  6'd31};
        vec[3] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd7,  6'd32};
        vec[4] = '{1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 5'd7,  6'd31};
        vec[5] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 5'd5,  6'd32};

        rst = 1'b1;
        bus.flush = 1'b0; bus.alloc_req = 1'b0; bus.free_en = 1'b0; bus.free_idx = 5'd0;
        do_reset();

        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 5'd0);
            chk("fill_idx", 32'(bus.alloc_idx), 32'(i));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_valid", bus.ram_valid, 32'hFFFF_FFFF);

        step(1'b0, 1'b1, 1'b0, 5'd0);
        chk("full_fail", 32'(bus.alloc_fail), 32'd1);
        chk("full_idx_hold", 32'(bus.alloc_idx), 32'd31);

        for (int v = 0; v < 6; v++) begin
            step(vec[v].fl, vec[v].al, vec[v].fe, vec[v].fi);
            chk("vec_gnt", 32'(bus.alloc_gnt), 32'(vec[v].e_gnt));
            chk("vec_fail", 32'(bus.alloc_fail), 32'(vec[v].e_fail));
            chk("vec_idx", 32'(bus.alloc_idx), 32'(vec[v].e_idx));
            chk("vec_cnt", 32'(bus.used_cnt), 32'(vec[v].e_cnt));
        end

        do_reset();
        step(1'b0, 1'b0, 1'b1, 5'd12);
        chk("bad_free_err", 32'(bus.err_free), 32'd1);
        chk("bad_free_cnt", 32'(bus.used_cnt), 32'd0);
        step(1'b0, 1'b0, 1'b0, 5'd0);
        chk("err_sticky", 32'(bus.err_free), 32'd1);
        step(1'b1, 1'b0, 1'b0, 5'd0);
        chk("flush_keeps_err", 32'(bus.err_free), 32'd1);
        do_reset();

        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 5'd0);
        step(1'b1, 1'b1, 1'b0, 5'd0);
        chk("flush_no_gnt", 32'(bus.alloc_gnt), 32'd0);
        chk("flush_no_fail", 32'(bus.alloc_fail), 32'd0);
        chk("flush_valid", bus.ram_valid, 32'h0);
        chk("flush_empty", 32'(bus.empty), 32'd1);
        // Free aimed at the slot being granted: illegal, grant still completes.
        step(1'b0, 1'b1, 1'b1, 5'd0);
        chk("post_flush_idx", 32'(bus.alloc_idx), 32'd0);
        chk("same_slot_gnt", 32'(bus.alloc_gnt), 32'd1);
        chk("same_slot_err", 32'(bus.err_free), 32'd1);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_slot_allocator.md
# ram_slot_allocator

Owns the 32-entry RAM slot occupancy bitmap of the memory system and hands out and reclaims slot indices. It drives the bitmap into the first-free-slot finder (`FirstZero`) and consumes the returned index to service allocation requests. It also retires freed slots, tracks occupancy, and flags illegal frees. All state updates are registered, so the finder path is purely register → combinational → register with no loop.

## Interface
- `SIZE_RAM`, 32, number of slots (bitmap width)
- `SIZE_RAM_LOG`, 5, slot index width

- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous clear of all slots (lower priority than `rst`)
- `alloc_req`  in  1  request one slot this cycle
- `free_en`  in  1  release slot `free_idx` this cycle
- `free_idx`  in  SIZE_RAM_LOG  slot to release
- `first_zero`  in  SIZE_RAM_LOG  lowest clear bit index of `ram_valid`, from finder
- `ram_valid`  out  SIZE_RAM  registered occupancy bitmap, 1 = slot in use
- `alloc_gnt`  out  1  one-cycle pulse: allocation succeeded
- `alloc_fail`  out  1  one-cycle pulse: allocation refused (full)
- `alloc_idx`  out  SIZE_RAM_LOG  granted index, valid while `alloc_gnt`=1
- `used_cnt`  out  SIZE_RAM_LOG+1  number of set bits in `ram_valid` (0..32)
- `full`, `empty`  out  1  `used_cnt`==32 / `used_cnt`==0, registered
- `err_free`  out  1  sticky: a free targeted an unallocated slot

## Operation
- Priority per cycle: `rst` > `flush` > (alloc, free).
- `rst`: `ram_valid`=0, `used_cnt`=0, `empty`=1, `full`=0, `alloc_gnt`=0, `alloc_fail`=0, `alloc_idx`=0, `err_free`=0.
- `flush`: same as reset except `err_free` holds; concurrent `alloc_req`/`free_en` discarded, no gnt/fail pulse.
- Full detection uses the registered `full` flag (AND of all bitmap bits), never `first_zero`: with all bits set the finder's 5-bit sum wraps to 0 and must be ignored.
- Alloc: if `alloc_req` and !`full`: set bit `first_zero`, `alloc_idx`<=`first_zero`, `alloc_gnt`<=1. If `full`: `alloc_fail`<=1, bitmap unchanged, `alloc_idx` holds.
- Free: if `free_en` and bit `free_idx` set: clear it. If bit clear: no change, `err_free`<=1 (sticky until `rst`).
- Simultaneous alloc + free: both applied in the same edge. Alloc sees the pre-free bitmap (no bypass): a free cannot rescue an alloc when `full`; a freed slot is reusable from the next cycle.
- Free of the slot being granted in the same cycle is impossible (its bit is clear) and is handled as an illegal free; the alloc still completes.
- `used_cnt` next = `used_cnt` + granted − legal_free; `full`/`empty` derived from next value and registered.
- No state machine beyond the bitmap and counters; every output is registered.

## Timing
- Request sampled at edge N; `alloc_gnt`/`alloc_fail`/`alloc_idx` valid in cycle N+1 for exactly one cycle.
- `ram_valid`, `used_cnt`, `full`, `empty` reflect cycle-N operations from N+1.
- Back-to-back `alloc_req` every cycle supported at full throughput; successive grants return increasing lowest free indices.
- Free latency: slot visible as free in `ram_valid` at N+1, allocatable by a request at N+1.
- `err_free` asserts at N+1 after the illegal free.
- `first_zero` must settle within the cycle from `ram_valid`; no other combinational input-to-output path.

## Test plan
- Reset then 32 consecutive `alloc_req` cycles -> `alloc_idx` 0,1,…,31 with `alloc_gnt` each cycle; `full`=1, `used_cnt`=32, `ram_valid`=0xFFFFFFFF.
- 33rd `alloc_req` while full -> `alloc_fail`=1, `alloc_gnt`=0, bitmap unchanged (finder's wrapped 0 ignored).
- From full, free 7 and 3 on successive cycles, then two allocs -> grants 3 then 7; `used_cnt` 30 → 32.
- Full bitmap, `alloc_req` and `free_en` idx 5 in the same cycle -> `alloc_fail`=1, bit 5 cleared, `used_cnt`=31; alloc next cycle -> idx 5.
- Free idx 12 on empty bitmap -> `err_free`=1 sticky, `used_cnt` stays 0; `flush` keeps `err_free`=1, `rst` clears it.
- 10 allocs, then `flush` together with `alloc_req` -> no gnt/fail pulse, `ram_valid`=0, `empty`=1; next alloc -> idx 0.
